// File: rtl/led_pulse_stretcher.sv
// rtl/led_pulse_stretcher.sv - stretches one-cycle events into visible LED blinks
//
// Each accepted event lights the LED for ON_TICKS slow ticks, then forces it
// dark for OFF_TICKS ticks. Events that arrive mid-blink are either queued
// (LED_STRETCH_QUEUE_EN defined) or dropped with a one-cycle overflow pulse.
//
// Ports:
//   clock_i     single clock, all logic on posedge
//   reset_i     asynchronous active-high reset
//   event_i     one-cycle event request
//   tick_i      one-cycle slow-time strobe
//   led_o       registered LED drive, 1 = lit
//   busy_o      registered, 1 while a blink or its dark gap is in progress
//   pending_o   events queued but not yet blinked (0 without the queue)
//   overflow_o  registered one-cycle pulse, the cycle after an event is dropped
//
// Optional feature macro: LED_STRETCH_QUEUE_EN

module led_pulse_stretcher #(
  parameter int ON_TICKS  = 3,
  parameter int OFF_TICKS = 2,
  parameter int PEND_MAX  = 2
) (
  input  logic                          clock_i,
  input  logic                          reset_i,
  input  logic                          event_i,
  input  logic                          tick_i,
  output logic                          led_o,
  output logic                          busy_o,
  output logic [$clog2(PEND_MAX+1)-1:0] pending_o,
  output logic                          overflow_o
);

  localparam int MAX_TICKS = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int CW        = $clog2(MAX_TICKS + 1);
  localparam int PW        = $clog2(PEND_MAX + 1);

  localparam logic [CW-1:0] ON_LAST  = CW'(ON_TICKS - 1);
  localparam logic [CW-1:0] OFF_LAST = CW'(OFF_TICKS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_OFF  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            led_q, busy_q, overflow_q;

  logic            off_exit;  // last tick of the dark gap lands this cycle
  logic            ev_busy;   // event arriving while a blink is in progress
  logic            pend_nz;   // a queued event is waiting
  logic            drop;      // event discarded this cycle

  assign off_exit = (state_q == S_OFF) && tick_i && (cnt_q == OFF_LAST);

  // Next-state and tick counter. The counter restarts at zero on every state
  // entry, so a tick in the cycle an event is accepted is never counted.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ev_busy = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (event_i) begin
          state_d = S_ON;
          cnt_d   = '0;
        end
      end
      S_ON: begin
        ev_busy = event_i;
        if (tick_i) begin
          if (cnt_q == ON_LAST) begin
            state_d = S_OFF;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_OFF: begin
        if (off_exit) begin
          cnt_d = '0;
          // Queued work has priority; otherwise an event arriving exactly on
          // the closing tick starts the next blink without a trip through IDLE.
          if (pend_nz) begin
            state_d = S_ON;
          end else if (event_i) begin
            state_d = S_ON;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          ev_busy = event_i;
          if (tick_i) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

`ifdef LED_STRETCH_QUEUE_EN
  logic [PW-1:0] pend_q, pend_d;

  // Dequeue on the OFF->ON restart. An event in that same cycle replaces the
  // slot being freed, so it is accepted even when the queue is full.
  always_comb begin
    pend_d = pend_q;
    drop   = 1'b0;
    if (off_exit && pend_nz) begin
      if (!event_i) begin
        pend_d = pend_q - 1'b1;
      end
    end else if (ev_busy) begin
      if (pend_q < PW'(PEND_MAX)) begin
        pend_d = pend_q + 1'b1;
      end else begin
        drop = 1'b1;
      end
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign pend_nz   = (pend_q != '0);
  assign pending_o = pend_q;
`else
  assign pend_nz   = 1'b0;
  assign drop      = ev_busy;
  assign pending_o = '0;
`endif

  // led/busy are registered from the next state so they are clean flop
  // outputs that track the state register exactly.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      led_q      <= 1'b0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      led_q      <= (state_d == S_ON);
      busy_q     <= (state_d != S_IDLE);
      overflow_q <= drop;
    end
  end

  assign led_o      = led_q;
  assign busy_o     = busy_q;
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_led_pulse_stretcher.sv
// tb/tb_led_pulse_stretcher.sv - randomized and directed check of led_pulse_stretcher

module tb_led_pulse_stretcher;

  localparam int ON_TICKS  = 3;
  localparam int OFF_TICKS = 2;
  localparam int PEND_MAX  = 2;
`ifdef LED_STRETCH_QUEUE_EN
  localparam int QCAP = PEND_MAX;
`else
  localparam int QCAP = 0;
`endif

  logic       clock_i, reset_i, event_i, tick_i;
  logic       led_o, busy_o, overflow_o;
  logic [1:0] pending_o;

  led_pulse_stretcher #(
    .ON_TICKS (ON_TICKS),
    .OFF_TICKS(OFF_TICKS),
    .PEND_MAX (PEND_MAX)
  ) dut (
    .clock_i   (clock_i),
    .reset_i   (reset_i),
    .event_i   (event_i),
    .tick_i    (tick_i),
    .led_o     (led_o),
    .busy_o    (busy_o),
    .pending_o (pending_o),
    .overflow_o(overflow_o)
  );

  initial clock_i = 1'b0;
  always #5 clock_i = ~clock_i;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: ticks left lit, ticks left dark, queued count.
  int m_on, m_off, m_q, m_ovf;

  task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_on = 0; m_off = 0; m_q = 0; m_ovf = 0;
  endtask

  task automatic model_enqueue();
    if (m_q < QCAP) m_q++;
    else m_ovf = 1;
  endtask

  task automatic model_update(input logic ev, input logic tk);
    m_ovf = 0;
    if (m_on > 0) begin
      if (ev) model_enqueue();
      if (tk) begin
        m_on--;
        if (m_on == 0) m_off = OFF_TICKS;
      end
    end else if (m_off > 0) begin
      if (tk && m_off == 1) begin
        m_off = 0;
        if (m_q > 0) begin
          m_on = ON_TICKS;
          if (!ev) m_q--;
        end else if (ev) begin
          m_on = ON_TICKS;
        end
      end else begin
        if (ev) model_enqueue();
        if (tk) m_off--;
      end
    end else if (ev) begin
      m_on = ON_TICKS;
    end
  endtask

  task automatic check_all();
    expect_eq("led",      led_o,      m_on > 0);
    expect_eq("busy",     busy_o,     (m_on > 0) || (m_off > 0));
    expect_eq("pending",  pending_o,  m_q);
    expect_eq("overflow", overflow_o, m_ovf);
  endtask

  // Called at a negedge; returns at the next negedge with outputs checked.
  task automatic step(input logic ev, input logic tk);
    event_i = ev;
    tick_i  = tk;
    @(posedge clock_i);
    model_update(ev, tk);
    #1;
    check_all();
    @(negedge clock_i);
  endtask

  task automatic do_reset(input int ncyc);
    reset_i = 1'b1;
    #1;
    model_clear();
    check_all();
    for (int i = 0; i < ncyc; i++) begin
      event_i = 1'($urandom);
      tick_i  = 1'($urandom);
      @(posedge clock_i);
      #1;
      check_all();
      @(negedge clock_i);
    end
    reset_i = 1'b0;
    event_i = 1'b0;
    tick_i  = 1'b0;
  endtask

  logic [31:0] ev_mask, led_mask, busy_mask, ovf_mask;
  int tdiv, edens;

  initial begin
    reset_i = 1'b1;
    event_i = 1'b0;
    tick_i  = 1'b0;
    model_clear();
    @(negedge clock_i);

    // Reset with inputs toggling, then IDLE must hold.
    do_reset(4);
    for (int c = 0; c < 6; c++) step(1'b0, 1'($urandom));

    // Single blink with tick tied high.
    do_reset(1);
    for (int c = 0; c < 18; c++) begin
      step(c == 10, 1'b1);
      expect_eq("blink_led",  led_o,  (c + 1 >= 11) && (c + 1 <= 13));
      expect_eq("blink_busy", busy_o, (c + 1 >= 11) && (c + 1 <= 15));
    end

    // Back-to-back events: queued or dropped depending on the build.
    do_reset(1);
`ifdef LED_STRETCH_QUEUE_EN
    ev_mask   = 32'hF << 10;
    led_mask  = (32'h7 << 11) | (32'h7 << 16) | (32'h7 << 21);
    busy_mask = 32'h7FFF << 11;
    ovf_mask  = 32'h1 << 14;
`else
    ev_mask   = (32'h1 << 10) | (32'h1 << 12) | (32'h1 << 15);
    led_mask  = (32'h7 << 11) | (32'h7 << 16);
    busy_mask = 32'h3FF << 11;
    ovf_mask  = 32'h1 << 13;
`endif
    for (int c = 0; c < 28; c++) begin
      step(ev_mask[c], 1'b1);
      expect_eq("burst_led",  led_o,      led_mask[c+1]);
      expect_eq("burst_busy", busy_o,     busy_mask[c+1]);
      expect_eq("burst_ovf",  overflow_o, ovf_mask[c+1]);
    end

    // Sparse tick: every 4th clock starting at 12.
    do_reset(1);
    for (int c = 0; c < 24; c++) begin
      step(c == 10, (c >= 12) && ((c - 12) % 4 == 0));
      expect_eq("sparse_led", led_o, (c + 1 >= 11) && (c + 1 <= 20));
    end

    // Reset mid-ON clears outputs asynchronously; no residual blink.
    do_reset(1);
    for (int c = 0; c < 12; c++) step(c == 10, 1'b1);
    reset_i = 1'b1;
    #1;
    expect_eq("midrst_led",     led_o,     0);
    expect_eq("midrst_busy",    busy_o,    0);
    expect_eq("midrst_pending", pending_o, 0);
    model_clear();
    @(posedge clock_i);
    #1;
    check_all();
    @(negedge clock_i);
    reset_i = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step(1'b0, 1'($urandom));
      expect_eq("post_rst_led", led_o, 0);
    end

    // Randomized segments with varying event and tick density.
    for (int seg = 0; seg < 24; seg++) begin
      tdiv  = $urandom_range(1, 5);
      edens = $urandom_range(1, 8);
      for (int i = 0; i < 100; i++) begin
        step($urandom_range(0, edens - 1) == 0, $urandom_range(0, tdiv - 1) == 0);
      end
      if ($urandom_range(0, 3) == 0) do_reset($urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/led_pulse_stretcher.md
# led_pulse_stretcher

Output-side counterpart to the button debouncer: turns single-cycle event pulses (debounced presses, status strobes) into human-visible LED blinks. Each accepted event produces one ON interval of `ON_TICKS` slow ticks followed by a mandatory OFF gap of `OFF_TICKS` ticks, so back-to-back events remain distinguishable. It sits between event sources in the fast clock domain and board LED pins, timed by a slow tick strobe from the same domain.

## Interface
- `ON_TICKS`, 3, ticks LED is lit per blink; >= 1
- `OFF_TICKS`, 2, ticks of forced dark gap after each blink; >= 1
- `PEND_MAX`, 2, max queued events (queue build only); >= 1

- `clock` in 1: single clock; all logic on posedge
- `reset` in 1: asynchronous, active-high; clears all state immediately
- `event` in 1: one-cycle request pulse, synchronous to `clock`
- `tick` in 1: one-cycle slow-time strobe, synchronous to `clock`
- `led` out 1: registered LED drive, 1 = lit
- `busy` out 1: registered, 1 whenever state != IDLE
- `pending` out clog2(PEND_MAX+1): queued events not yet blinked
- `overflow` out 1: registered one-cycle pulse, cycle after an event is dropped

## Operation
- States: IDLE, ON, OFF. Tick counter width clog2(max(ON_TICKS,OFF_TICKS)+1); cleared on every state entry.
- IDLE: `event`=1 -> ON. Otherwise stay.
- ON: `tick`=1 increments counter; `tick`=1 with counter == ON_TICKS-1 -> OFF.
- OFF: same rule with OFF_TICKS-1. On exit: `pending`>0 -> ON and `pending` decrements; else `event`=1 this cycle -> ON; else IDLE.
- `event` in ON/OFF: queued (`pending`+1) if `pending` < PEND_MAX (queue build), else dropped with `overflow` pulse.
- Simultaneous enqueue and OFF->ON dequeue: `pending` unchanged; the new event is accepted even when `pending` == PEND_MAX.
- `tick` in IDLE is ignored. A `tick` in the cycle an event is accepted is not counted.
- `led` = (state == ON); `busy` = (state != IDLE); both derived from the state register, glitch-free.
- Reset values: state IDLE, counter 0, `led` 0, `busy` 0, `pending` 0, `overflow` 0.

## Timing
- Event in cycle n from IDLE: `led` and `busy` high from n+1.
- With `tick` tied high: `led` high exactly ON_TICKS cycles, then low OFF_TICKS cycles before the next blink or IDLE.
- General: ON duration ends at the clock edge closing the ON_TICKS-th tick counted after entry.
- `overflow` is high in cycle m+1 for a drop in cycle m, for exactly one cycle; a new drop in m+1 keeps it high in m+2.
- Reset asserted mid-blink forces `led`, `busy`, `pending` to 0 asynchronously. After release, no residual blink occurs.

## Configuration
- `LED_STRETCH_QUEUE_EN` defined: pending counter is implemented with the enqueue/dequeue rules above.
- Not defined: no queue. `pending` is tied to 0. Any `event` in ON/OFF is dropped with an `overflow` pulse, except an `event` in the final OFF cycle, which starts the next blink as stated above.

## Test plan
- Reset: assert `reset` with `event`/`tick` toggling -> `led`, `busy`, `pending`, `overflow` all 0; IDLE holds after release with no event.
- Single blink (defaults, `tick`=1): `event` at cycle 10 -> `led`=1 in cycles 11-13; `led`=0 with `busy`=1 in 14-15; `busy`=0 from 16.
- Queue (macro on, `tick`=1): events at 10, 11, 12, 13 -> `pending` 1 at 12, 2 at 13; `overflow`=1 only in cycle 14; `led` on 11-13, 16-18, 21-23; `busy`=0 from 26.
- No queue (macro off): events at 10 and 12 -> a single blink on 11-13; `overflow`=1 in 13; an event at 15 starts a blink on 16-18.
- Sparse tick (`tick` every 4th clock, first at 12): `event` at 10 -> `led` high 11 through 20, low from 21 (ticks 12, 16, 20).
- Reset mid-ON: `event` at 10, `reset` pulsed in 12 -> `led`=0 within cycle 12, `pending`=0; no blink after release until a new `event`.
